// File: rtl/spi_pkg.sv
// Shared constants for the SPI register-file peripheral: RW encoding,
// default geometry and the frame-length helper.
package spi_pkg;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 7;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with a third flop
// holding the previous synced level for rise/fall detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a small register file: RW bit, address
// and data are shifted in MSB first; writes commit when nCS rises.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_sync;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d_i(nCS),
    .sync_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK),
    .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d_i(COPI),
    .sync_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic               rd_q, rd_d;
  logic               act_q, act_d;
  logic [1:0]         settle_q, settle_d;
  logic               idle_seen_q, idle_seen_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               frame_err_q, frame_err_d;

  logic [ADDR_W-1:0]  frame_addr, hdr_addr;
  rw_e                frame_rw, hdr_rw;

  assign frame_rw   = rw_e'(rx_q[FRAME_W-1]);
  assign frame_addr = rx_q[DATA_W +: ADDR_W];
  assign hdr_rw     = rw_e'(rx_q[ADDR_W]);
  assign hdr_addr   = rx_q[ADDR_W-1:0];

  // NOTE: every signal written here gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    act_d       = act_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    settle_d    = {settle_q[0], 1'b1};
    // A frame may only open once nCS has been seen high through a flushed
    // synchroniser; this swallows the false fall after a mid-frame reset.
    idle_seen_d = idle_seen_q | (settle_q[1] & ncs_lvl);

    if (ncs_fall && idle_seen_q) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = '0;
      rd_d  = 1'b0;
      act_d = 1'b1;
    end else if (ncs_rise) begin
      if (act_q) begin
        act_d = 1'b0;
        if (cnt_q == CNT_FRAME && addr_ok(frame_addr)) begin
          if (frame_rw == RW_WRITE) begin
            regs_d[IDX_W'(frame_addr)] = rx_q[DATA_W-1:0];
            wr_addr_d  = frame_addr;
            wr_pulse_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (!ncs_lvl && act_q) begin
      if (sclk_rise) begin
        rx_d = {rx_q[FRAME_W-2:0], copi_lvl};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (sclk_fall) begin
        if (cnt_q == CNT_HDR && hdr_rw == RW_READ) begin
          tx_d = addr_ok(hdr_addr) ? regs_q[IDX_W'(hdr_addr)] : '0;
          rd_d = 1'b1;
        end else if (rd_q) begin
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // NOTE: the register file is reset explicitly because regs_out must read
  // zero after reset; large RAM-style arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      act_q       <= 1'b0;
      settle_q    <= '0;
      idle_seen_q <= 1'b0;
      regs_q      <= '{default: '0};
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      act_q       <= act_d;
      settle_q    <= settle_d;
      idle_seen_q <= idle_seen_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign CIPO_oe   = rd_q & ~ncs_lvl;
  assign CIPO      = CIPO_oe & tx_q[DATA_W-1];
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of DATA_W-bit registers (1..2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, register and data-field width.
REQ-003 SHALL have parameter ADDR_W, default 7, address-field width; frame length FRAME_W = 1+ADDR_W+DATA_W (default 16).
REQ-004 SHALL have port clk  input  1  sole clock; SCLK, nCS and COPI are asynchronous to it.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports nCS, SCLK, COPI  input  1 each  SPI chip-select (active-low), serial clock (mode 0), controller data.
REQ-007 SHALL have port CIPO  output  1  peripheral read data.
REQ-008 SHALL have port CIPO_oe  output  1  high while a read data phase is active.
REQ-009 SHALL have port regs_out  output  NUM_REGS*DATA_W  flattened register file, reg i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port wr_pulse  output  1  one-cycle strobe on each committed write.
REQ-011 SHALL have port wr_addr  output  ADDR_W  address of the last committed write.
REQ-012 SHALL have port frame_err  output  1  one-cycle strobe on a rejected frame.

Function
REQ-013 SHALL synchronise nCS, SCLK and COPI through two flops each and detect edges against a third (prev) flop; clk SHALL be at least 8x SCLK.
REQ-014 Frame format, MSB first: bit FRAME_W-1 = RW (1 write, 0 read), then ADDR_W address bits, then DATA_W data bits.
REQ-015 On synced nCS falling: bit counter, RX shift register, TX shift register and read flag SHALL clear.
REQ-016 On synced SCLK rising with synced nCS low: shift synced COPI into RX LSB; counter SHALL increment and saturate at FRAME_W+1.
REQ-017 On synced SCLK falling with nCS low, counter == 1+ADDR_W and RW == 0: TX SHALL load reg[addr] (zero if addr >= NUM_REGS) and the read flag SHALL set.
REQ-018 On each later synced SCLK falling with the read flag set: TX SHALL shift left one bit, zero-filled.
REQ-019 CIPO SHALL equal TX MSB while the read flag is set and synced nCS is low, else 0; CIPO_oe SHALL equal the same condition.
REQ-020 On synced nCS rising with counter == FRAME_W, RW == 1 and addr < NUM_REGS: reg[addr] SHALL take the data field, wr_addr SHALL take addr and wr_pulse SHALL be high for exactly the next cycle.
REQ-021 On synced nCS rising with counter != FRAME_W (short or overlong) or addr >= NUM_REGS, for either RW value: no register SHALL change and frame_err SHALL pulse for one cycle.
REQ-022 A read frame of exactly FRAME_W bits with a valid address SHALL change no register and pulse neither strobe.
REQ-023 Each frame SHALL commit at most once; an nCS rising edge without a preceding falling edge SHALL be ignored.
REQ-024 SCLK edge and nCS rising in the same cycle: the SCLK edge SHALL be ignored and the frame-end evaluation SHALL use the prior counter value.
REQ-025 Write latency: regs_out SHALL reflect new data on the cycle wr_pulse is high (3 clk after nCS pin rise, synchroniser included).

Reset
REQ-026 While rst is high at a clk edge: regs_out = 0, wr_addr = 0, wr_pulse = 0, frame_err = 0, CIPO = 0, CIPO_oe = 0, counter/shift/read flag = 0, nCS sync/prev flops = 1, SCLK/COPI flops = 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; the nCS rising edge that follows SHALL produce no write and no frame_err.

Structure
REQ-028 Package spi_pkg SHALL hold the RW encoding constants, the default parameter values and a FRAME_W helper function.
REQ-029 Sub-module spi_sync_edge (2-flop sync plus rise/fall detect, parametric reset value) SHALL be instantiated once each for nCS, SCLK and COPI.

Verification
REQ-030 Write 0x83_A5 (reg 3 = 0xA5) -> regs_out[31:24] = 0xA5, wr_pulse one cycle, wr_addr = 3; all other registers stay 0.
REQ-031 After REQ-030, read frame 0x03_00 -> CIPO shifts out 1010_0101 on SCLK rises 9-16, CIPO_oe high for that phase, no strobes.
REQ-032 Write to addr 8 (0x88_FF) and a 12-bit frame 0x81_F -> frame_err pulses once each, regs_out unchanged.
REQ-033 17-bit write frame -> frame_err, no write; a following valid 16-bit write to reg 0 commits normally.
REQ-034 rst asserted after 10 bits of a write frame, released while nCS is low -> no write and no frame_err at nCS rise; regs_out = 0.
REQ-035 Back-to-back writes to regs 0 and 7 with 4-clk nCS-high gap -> two wr_pulses, both registers updated.
